// File: rtl/mu0_pkg.sv
// MU0 shared encodings: opcodes, ALU functions, mux selects, FSM states
// and the control vector the decoder produces.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] FS_Y   = 2'b00;
    localparam logic [1:0] FS_ADD = 2'b01;
    localparam logic [1:0] FS_INC = 2'b10;
    localparam logic [1:0] FS_SUB = 2'b11;

    localparam logic X_ACC   = 1'b0;
    localparam logic X_PC    = 1'b1;
    localparam logic Y_MEM   = 1'b0;
    localparam logic Y_IR    = 1'b1;
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] alu_fs;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mu0_control_if.sv
// Control bus between the MU0 controller and its datapath.
// MU0_MEM_WAIT_EN adds the Mem_ready handshake from memory.
interface mu0_control_if;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       X_sel;
    logic       Y_sel;
    logic       Addr_sel;
    logic       PC_En;
    logic       IR_En;
    logic       Acc_En;
    logic [1:0] ALU_fs;
    logic       Mem_rd;
    logic       Mem_wr;
    logic       Halted;
`ifdef MU0_MEM_WAIT_EN
    logic       Mem_ready;
`endif

    // controller side
    modport master (
        input  F, N, Z,
`ifdef MU0_MEM_WAIT_EN
        input  Mem_ready,
`endif
        output X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En,
        output ALU_fs, Mem_rd, Mem_wr, Halted
    );

    // datapath side
    modport slave (
        output F, N, Z,
`ifdef MU0_MEM_WAIT_EN
        output Mem_ready,
`endif
        input  X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En,
        input  ALU_fs, Mem_rd, Mem_wr, Halted
    );
endinterface

// File: rtl/mu0_decode.sv
// Purely combinational MU0 decoder: (state, opcode, flags) -> control vector.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl
);

    // Decode one control vector per cycle; anything not set stays 0.
    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            ST_FETCH: begin
                ctrl.addr_sel = ADDR_PC;
                ctrl.mem_rd   = 1'b1;
                ctrl.ir_en    = 1'b1;
                ctrl.x_sel    = X_PC;
                ctrl.alu_fs   = FS_INC;
                ctrl.pc_en    = 1'b1;
            end
            ST_EXEC: begin
                // Conditional jumps fall back to an all-idle vector when not taken.
                if (f == OP_JMP || (f == OP_JGE && !n) || (f == OP_JNE && !z)) begin
                    ctrl.y_sel  = Y_IR;
                    ctrl.alu_fs = FS_Y;
                    ctrl.pc_en  = 1'b1;
                end else if (f == OP_LDA) begin
                    ctrl.addr_sel = ADDR_IR;
                    ctrl.mem_rd   = 1'b1;
                    ctrl.y_sel    = Y_MEM;
                    ctrl.alu_fs   = FS_Y;
                    ctrl.acc_en   = 1'b1;
                end else if (f == OP_STA) begin
                    ctrl.addr_sel = ADDR_IR;
                    ctrl.mem_wr   = 1'b1;
                end else if (f == OP_ADD || f == OP_SUB) begin
                    ctrl.addr_sel = ADDR_IR;
                    ctrl.mem_rd   = 1'b1;
                    ctrl.x_sel    = X_ACC;
                    ctrl.y_sel    = Y_MEM;
                    ctrl.alu_fs   = (f == OP_ADD) ? FS_ADD : FS_SUB;
                    ctrl.acc_en   = 1'b1;
                end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute controller: state register, next-state logic,
// reset gating of the control vector and optional memory wait states.
// Optional feature macro: MU0_MEM_WAIT_EN (adds Mem_ready stalls).
module mu0_control
    import mu0_pkg::*;
(
    input  logic          Clk,
    input  logic          nReset,
    mu0_control_if.master bus
);

    state_t state, state_nxt;
    ctrl_t  dec, ctrl;
    logic   stall;

    mu0_decode u_decode (
        .state (state),
        .f     (bus.F),
        .n     (bus.N),
        .z     (bus.Z),
        .ctrl  (dec)
    );

`ifdef MU0_MEM_WAIT_EN
    // A memory access that memory has not acknowledged holds the current state.
    assign stall = (dec.mem_rd | dec.mem_wr) & ~bus.Mem_ready;
`else
    assign stall = 1'b0;
`endif

    // Next state: FETCH->EXEC->FETCH, STP parks in HALT until reset.
    always_comb begin
        state_nxt = state;
        if (!stall) begin
            unique case (state)
                ST_FETCH: state_nxt = ST_EXEC;
                ST_EXEC:  state_nxt = (bus.F == OP_STP) ? ST_HALT : ST_FETCH;
                ST_HALT:  state_nxt = ST_HALT;
                default:  state_nxt = ST_FETCH;
            endcase
        end
    end

    // Output gating: stalls drop register enables, reset blanks everything at once.
    always_comb begin
        ctrl = dec;
        if (stall) begin
            ctrl.pc_en  = 1'b0;
            ctrl.ir_en  = 1'b0;
            ctrl.acc_en = 1'b0;
        end
        if (!nReset) ctrl = CTRL_IDLE;
    end

    // State register, asynchronously forced to FETCH.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= ST_FETCH;
        else         state <= state_nxt;
    end

    assign bus.X_sel    = ctrl.x_sel;
    assign bus.Y_sel    = ctrl.y_sel;
    assign bus.Addr_sel = ctrl.addr_sel;
    assign bus.PC_En    = ctrl.pc_en;
    assign bus.IR_En    = ctrl.ir_en;
    assign bus.Acc_En   = ctrl.acc_en;
    assign bus.ALU_fs   = ctrl.alu_fs;
    assign bus.Mem_rd   = ctrl.mem_rd;
    assign bus.Mem_wr   = ctrl.mem_wr;
    assign bus.Halted   = ctrl.halted;

endmodule
